apb_master_bridge: RTL and testbench
====================================

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles to wait for PREADY before aborting.
REQ-002 SHALL have parameter ADDR_W, default 64: width of the request and APB address.
REQ-003 SHALL have parameter DATA_W, default 64: width of the request and APB data.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port PRESETn, input, 1 bit: reset, synchronous and active-high (asserted = 1).
REQ-006 SHALL have port req_valid, input, 1 bit: the requester presents a command.
REQ-007 SHALL have port req_ready, output, 1 bit: the bridge accepts a command this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W bits: command byte/word address.
REQ-010 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, DATA_W bits: read data, valid with resp_valid.
REQ-013 SHALL have port resp_err, output, 1 bit: error flag, valid with resp_valid.
REQ-014 SHALL have APB outputs cs, PSEL1, PSEL2, PENABLE and PWRITE (1 bit each), and PADDR and PWDATA (ADDR_W and DATA_W bits).
REQ-015 SHALL have APB inputs PRDATA (DATA_W bits), PREADY (1 bit) and slverr (1 bit), driven by the selected slave.

Function
REQ-016 FSM SHALL have states IDLE, SETUP, ACCESS, GAP; all outputs registered.
REQ-017 req_ready SHALL be 1 only in IDLE; a command is accepted when req_valid && req_ready.
REQ-018 Decode on acceptance: req_addr[ADDR_W-1:7] != 0 -> no APB transfer, resp_valid=1 with resp_err=1 next cycle, FSM to GAP.
REQ-019 Otherwise req_addr[6]=0 selects PSEL1=1,PSEL2=0 and req_addr[6]=1 selects PSEL1=0,PSEL2=1; the bridge SHALL register PADDR=req_addr, PWRITE and PWDATA, then go to SETUP.
REQ-020 SETUP (one cycle): cs=1, PENABLE=0, PSEL and address/data stable; the next state SHALL be ACCESS.
REQ-021 ACCESS: cs=1, PENABLE=1; PREADY SHALL be sampled only in ACCESS and ignored in all other states.
REQ-022 PREADY=1 in ACCESS: the bridge SHALL capture PRDATA (reads only; 0 on writes) and resp_err=slverr, pulse resp_valid the next cycle, and go to GAP.
REQ-023 Watchdog: count ACCESS cycles from 1; at count==TIMEOUT with PREADY=0, the bridge SHALL abort with resp_valid=1, resp_err=1, resp_rdata=0, and go to GAP.
REQ-024 GAP (exactly one cycle): cs=0, PENABLE=0, PSEL1=PSEL2=0; it clears the slave's registered PREADY, which is otherwise stale for one cycle; the next state SHALL be IDLE.
REQ-025 Minimum latency, accept to resp_valid: 4 cycles (SETUP, ACCESS wait, ACCESS ready, response); throughput: at most one transfer per 5 cycles.
REQ-026 PADDR, PWDATA and PWRITE SHALL hold their last values outside transfers; PSEL1 and PSEL2 SHALL never both be 1.
REQ-027 resp_valid SHALL have no backpressure; resp_rdata and resp_err SHALL hold until the next response.

Reset
REQ-028 While PRESETn=1 at a PCLK edge: state=IDLE; cs, PSEL1, PSEL2, PENABLE, PWRITE, resp_valid, resp_err = 0; PADDR, PWDATA, resp_rdata = 0; watchdog = 0.
REQ-029 req_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-030 Reset mid-transfer SHALL abort it silently: no resp_valid pulse and APB outputs deasserted on the same edge.

Structure
REQ-031 Package apb_pkg SHALL hold the state enum, the decode constants (SEL_BIT=6, the 128-word valid window) and the default TIMEOUT.
REQ-032 Sub-module apb_wdog SHALL implement the watchdog (inputs: clear, enable; output: expired); all other logic SHALL be in the top module.

Verification
REQ-033 Write: write addr 0x45, data 0xDEAD_BEEF -> PSEL2=1, SETUP then ACCESS; slave2 word 5 = 0xDEAD_BEEF; resp_valid with resp_err=0, 4 cycles after acceptance.
REQ-034 Read-back: read addr 0x45 -> resp_rdata=0xDEAD_BEEF, resp_err=0; PSEL1 stays 0 throughout.
REQ-035 Decode error: read addr 0x80 -> no cs or PSEL activity; resp_valid the next cycle with resp_err=1.
REQ-036 Timeout: slave PREADY tied 0 -> resp_err=1 exactly after TIMEOUT=16 ACCESS cycles; then GAP, then IDLE.
REQ-037 Back-to-back: req_valid held high over 3 commands -> each transfer is separated by one GAP cycle with cs=0 and PENABLE=0, and there is no early completion from a stale PREADY.
REQ-038 Reset mid-transfer: PRESETn=1 in ACCESS -> all outputs reach their reset values next edge; no resp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared state encoding, address decode constants and default
//               watchdog limit for the APB master bridge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

   localparam int SEL_BIT     = 6;   // picks slave 1 (0) or slave 2 (1)
   localparam int WIN_BITS    = 7;   // 128-word valid window below this bit
   localparam int TIMEOUT_DEF = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETUP  = 2'd1;
   localparam state_t ST_ACCESS = 2'd2;
   localparam state_t ST_GAP    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/apb_wdog.sv
// ============================================================================
// Module      : apb_wdog
// Description : ACCESS-phase watchdog; expired_o flags the TIMEOUT-th enabled
//               cycle since the last clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb_wdog
   import apb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds completed cycles, so the current cycle number is cnt_q + 1
   assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ============================================================================
// Module      : apb_master_bridge
// Description : Valid/ready command to two-slave APB master with address
//               decode, ACCESS watchdog and a one-cycle GAP between transfers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              cs,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              slverr
);

   state_t            state_q, state_d;
   logic              cs_q, cs_d;
   logic              psel1_q, psel1_d;
   logic              psel2_q, psel2_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic              req_ready_q, req_ready_d;
   logic              w_expired;

   apb_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .clear_i   (state_q != ST_ACCESS),
      .enable_i  (state_q == ST_ACCESS),
      .expired_o (w_expired)
   );

   always_comb begin
      state_d      = state_q;
      cs_d         = cs_q;
      psel1_d      = psel1_q;
      psel2_d      = psel2_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (req_addr[ADDR_W-1:WIN_BITS] != '0) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = ST_GAP;
               end else begin
                  paddr_d  = req_addr;
                  pwrite_d = req_write;
                  pwdata_d = req_wdata;
                  psel1_d  = !req_addr[SEL_BIT];
                  psel2_d  = req_addr[SEL_BIT];
                  cs_d     = 1'b1;
                  state_d  = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY || w_expired) begin
               resp_valid_d = 1'b1;
               resp_err_d   = PREADY ? slverr : 1'b1;
               resp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
               cs_d         = 1'b0;
               psel1_d      = 1'b0;
               psel2_d      = 1'b0;
               penable_d    = 1'b0;
               state_d      = ST_GAP;
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn) begin
         state_q      <= ST_IDLE;
         cs_q         <= 1'b0;
         psel1_q      <= 1'b0;
         psel2_q      <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         req_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cs_q         <= cs_d;
         psel1_q      <= psel1_d;
         psel2_q      <= psel2_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         req_ready_q  <= req_ready_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign cs         = cs_q;
   assign PSEL1      = psel1_q;
   assign PSEL2      = psel2_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Scoreboard bench for apb_master_bridge with two registered
//               APB slaves and a memory-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_master_bridge;

   localparam int TO = 16;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic        req_hang = 1'b0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        cs, PSEL1, PSEL2, PENABLE, PWRITE;
   logic [63:0] PADDR, PWDATA;
   logic [63:0] PRDATA;
   logic        PREADY;
   logic        slverr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   apb_master_bridge u_dut (
      .PCLK       (PCLK),
      .PRESETn    (PRESETn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .cs         (cs),
      .PSEL1      (PSEL1),
      .PSEL2      (PSEL2),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .slverr     (slverr)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      if (cyc > 50000) begin
         $display("FAIL global_timeout cycles=%0d limit=50000", cyc);
         $fatal(1);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Slaves: registered PREADY/PRDATA; word 63 of each slave answers SLVERR and ignores writes
   logic [63:0] smem [2][64];
   logic [63:0] mmem [2][64];
   logic        hang_cur = 1'b0;

   initial begin
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 64; w++) begin
            smem[s][w] = '0;
            mmem[s][w] = '0;
         end
   end

   always @(posedge PCLK) begin
      if (PRESETn) begin
         PREADY <= 1'b0;
         PRDATA <= '0;
         slverr <= 1'b0;
      end else begin
         PREADY <= (PSEL1 || PSEL2) && PENABLE && !hang_cur;
         if ((PSEL1 || PSEL2) && PENABLE) begin
            PRDATA <= smem[PSEL2][PADDR[5:0]];
            slverr <= (PADDR[5:0] == 6'd63);
         end
         if ((PSEL1 || PSEL2) && PENABLE && PREADY && PWRITE && PADDR[5:0] != 6'd63)
            smem[PSEL2][PADDR[5:0]] <= PWDATA;
      end
   end

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          ncs;
      int          npen;
   } exp_t;

   exp_t sbq[$];

   task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic hang, output exp_t e);
      int s, wd;
      s  = int'(a[6]);
      wd = int'(a[5:0]);
      if (a >= 64'd128) begin
         e = '{64'd0, 1'b1, 1, 0, 0};
      end else if (hang) begin
         e = '{64'd0, 1'b1, TO + 2, TO + 1, TO};
      end else begin
         e.err = (wd == 63);
         e.lat = 4; e.ncs = 3; e.npen = 2;
         if (w) begin
            if (wd != 63) mmem[s][wd] = d;
            e.rdata = '0;
         end else begin
            e.rdata = mmem[s][wd];
         end
      end
   endtask

   int   acc_cyc = 0;
   int   cs_cnt = 0;
   int   pen_cnt = 0;
   logic after_resp = 1'b0;
   logic psel1_seen = 1'b0;
   logic psel2_seen = 1'b0;

   always @(negedge PCLK) begin
      exp_t e, n;
      if (PRESETn) begin
         sbq.delete();
         hang_cur   = 1'b0;
         after_resp = 1'b0;
      end else begin
         if (resp_valid) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_resp actual=1 required=0");
            end else begin
               e = sbq.pop_front();
               chk("resp_rdata", resp_rdata, e.rdata);
               chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
               chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
               chk("cs_cycles", 64'(cs_cnt), 64'(e.ncs));
               chk("penable_cycles", 64'(pen_cnt), 64'(e.npen));
            end
            chk("gap_bus_idle", {60'd0, cs, PENABLE, PSEL1, PSEL2}, 64'd0);
            chk("gap_not_ready", {63'd0, req_ready}, 64'd0);
            after_resp = 1'b1;
         end else if (after_resp) begin
            chk("idle_after_gap", {63'd0, req_ready}, 64'd1);
            after_resp = 1'b0;
         end
         if (cs || PSEL1 || PSEL2) begin
            chk("psel_onehot", {62'd0, PSEL1, PSEL2}, PADDR[6] ? 64'd1 : 64'd2);
            chk("cs_with_psel", {63'd0, cs}, 64'd1);
         end
         if (PENABLE) chk("penable_in_cs", {63'd0, cs}, 64'd1);
         psel1_seen = psel1_seen | PSEL1;
         psel2_seen = psel2_seen | PSEL2;
         cs_cnt  += int'(cs);
         pen_cnt += int'(PENABLE);
         if (req_valid && req_ready) begin
            model(req_write, req_addr, req_wdata, req_hang, n);
            sbq.push_back(n);
            acc_cyc  = cyc;
            cs_cnt   = 0;
            pen_cnt  = 0;
            hang_cur = req_hang;
         end
      end
   end

   task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d, input logic hang);
      int n = 0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_hang = hang;
      @(negedge PCLK);
      while (!req_ready && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL accept_wait actual=%0d required<100", n);
      end
      @(posedge PCLK); #1;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      req_valid = 1'b0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge PCLK);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_wait actual=%0d required=0", sbq.size());
      end
      repeat (2) @(posedge PCLK);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, {56'd0, cs, PSEL1, PSEL2, PENABLE, PWRITE, resp_valid, resp_err, req_ready}, 64'd0);
      chk({tag, "_paddr"}, PADDR, 64'd0);
      chk({tag, "_pwdata"}, PWDATA, 64'd0);
      chk({tag, "_rdata"}, resp_rdata, 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      logic [63:0] one;
      int          k;

      repeat (3) @(posedge PCLK);
      #1;
      chk_reset_outputs("reset");
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

      // Directed: write then read back through slave 2
      psel1_seen = 1'b0; psel2_seen = 1'b0;
      send(1'b1, 64'h45, 64'hDEAD_BEEF, 1'b0);
      drain();
      chk("slave2_word5", smem[1][5], 64'hDEAD_BEEF);
      send(1'b0, 64'h45, 64'h0, 1'b0);
      drain();
      chk("readback_hold", resp_rdata, 64'hDEAD_BEEF);
      chk("readback_err", {63'd0, resp_err}, 64'd0);
      chk("psel1_quiet", {63'd0, psel1_seen}, 64'd0);
      chk("psel2_used", {63'd0, psel2_seen}, 64'd1);

      // Decode error and watchdog timeout
      send(1'b0, 64'h80, 64'h0, 1'b0);
      drain();
      send(1'b0, 64'h10, 64'h0, 1'b1);
      drain();

      // Back-to-back with req_valid held
      send(1'b1, 64'h03, 64'h1111_2222_3333_4444, 1'b0);
      send(1'b1, 64'h44, 64'h5555_6666_7777_8888, 1'b0);
      send(1'b0, 64'h03, 64'h0, 1'b0);
      drain();

      // Reset while in ACCESS
      send(1'b0, 64'h07, 64'h0, 1'b0);
      req_valid = 1'b0;
      k = 0;
      while (!PENABLE && k < 20) begin
         @(negedge PCLK);
         k++;
      end
      chk("reached_access", {63'd0, PENABLE}, 64'd1);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;
      chk_reset_outputs("midreset");
      @(posedge PCLK); #1;
      PRESETn = 1'b0;
      @(posedge PCLK); #1;
      chk("ready_after_midreset", {63'd0, req_ready}, 64'd1);
      idle(6);

      // Randomized traffic
      one = 64'd1;
      for (int t = 0; t < 60; t++) begin
         a = 64'($urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) a = a | (one << $urandom_range(7, 63));
         send(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
         k = $urandom_range(0, 2);
         if (k != 0) idle(k);
      end
      drain();
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 64; w++)
            chk("final_mem", smem[s][w], mmem[s][w]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
